// File: rtl/sample_mem_pkg.sv
// sample_mem_pkg
//   Shared definitions for the wide logic-analyzer sample memory:
//   status register bit positions, register offsets relative to the
//   block base address, and helpers that derive the per-sample word
//   count and the power-of-two address stride from the probe width.
package sample_mem_pkg;

    localparam int ST_EMPTY    = 0;
    localparam int ST_FULL     = 1;
    localparam int ST_OVERFLOW = 2;
    localparam int ST_MODE     = 3;

    localparam logic [15:0] OFF_STATUS = 16'd0;
    localparam logic [15:0] OFF_SIZE   = 16'd1;
    localparam logic [15:0] OFF_DATA   = 16'd2;

    // 16-bit bus words needed to hold one sample.
    function automatic int calc_words(input int width);
        return (width + 15) / 16;
    endfunction

    // Smallest power of two that is >= words. Keeps s and k as plain bit
    // fields of the data offset.
    function automatic int calc_stride(input int words);
        int s;
        s = 1;
        for (int i = 0; i < 16; i++) begin
            if (s < words) s = s * 2;
        end
        return s;
    endfunction

endpackage

// File: rtl/dual_port_bram.sv
// dual_port_bram
//   Simple dual-port block RAM with one registered read port (a) and one
//   write port (b). The contents have no reset.
//   Ports:
//     clka, addra, douta         - read port, one cycle read latency
//     clkb, addrb, dinb, web     - write port
module dual_port_bram #(
    parameter int RAM_WIDTH = 16,
    parameter int RAM_DEPTH = 1024,
    parameter int ADDR_W    = $clog2(RAM_DEPTH)
) (
    input  logic                 clka,
    input  logic [ADDR_W-1:0]    addra,
    output logic [RAM_WIDTH-1:0] douta,
    input  logic                 clkb,
    input  logic [ADDR_W-1:0]    addrb,
    input  logic [RAM_WIDTH-1:0] dinb,
    input  logic                 web
);

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

    always_ff @(posedge clka) begin
        douta <= mem[addra];
    end

    always_ff @(posedge clkb) begin
        if (web) mem[addrb] <= dinb;
    end

endmodule

// File: rtl/sample_mem_wide.sv
// sample_mem_wide
//   Circular sample FIFO for the logic analyzer. Captures probe samples of
//   SAMPLE_WIDTH bits into a SAMPLE_DEPTH-deep BRAM. It has two modes:
//   stop-when-full, or overwrite-oldest to keep pre-trigger history. Status,
//   size and all stored samples (oldest first) are readable on the 16-bit
//   daisy-chained register bus. The bus has a fixed latency of 2 cycles.
//   Ports:
//     clk, rst                          - clock, synchronous active-high reset
//     probe_data, acquire, mode         - capture input and capture mode
//     pop, clear                        - discard oldest / empty the FIFO
//     size, full, overflow              - FIFO status
//     addr_i, wdata_i, rdata_i, rw_i, valid_i  - bus input (rw=1 is write)
//     addr_o, wdata_o, rdata_o, rw_o, valid_o  - bus output, two stages later
module sample_mem_wide
    import sample_mem_pkg::*;
#(
    parameter int BASE_ADDR    = 0,
    parameter int SAMPLE_DEPTH = 1024,
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [SAMPLE_WIDTH-1:0]      probe_data,
    input  logic                         acquire,
    input  logic                         mode,
    input  logic                         pop,
    input  logic                         clear,
    output logic [$clog2(SAMPLE_DEPTH):0] size,
    output logic                         full,
    output logic                         overflow,
    input  logic [15:0]                  addr_i,
    input  logic [15:0]                  wdata_i,
    input  logic [15:0]                  rdata_i,
    input  logic                         rw_i,
    input  logic                         valid_i,
    output logic [15:0]                  addr_o,
    output logic [15:0]                  wdata_o,
    output logic [15:0]                  rdata_o,
    output logic                         rw_o,
    output logic                         valid_o
);

    localparam int WORDS  = calc_words(SAMPLE_WIDTH);
    localparam int STRIDE = calc_stride(WORDS);
    localparam int AW     = $clog2(SAMPLE_DEPTH);
    localparam int SB     = $clog2(STRIDE);
    localparam int RAM_W  = WORDS * 16;

    localparam logic [16:0] ADDR_LO   = 17'(BASE_ADDR);
    localparam logic [16:0] ADDR_HI   = 17'(BASE_ADDR + 2 + SAMPLE_DEPTH * STRIDE);
    localparam logic [15:0] BASE16    = 16'(BASE_ADDR);
    localparam logic [15:0] K_MASK    = 16'(STRIDE - 1);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(SAMPLE_DEPTH);
    localparam logic [AW:0] PTR_ONE   = (AW + 1)'(1);

    // ---------------- capture side ----------------
    logic [AW:0] wp, rp, wp_nxt, rp_nxt;
    logic        ovf_nxt, ram_we, empty;

    logic [15:0] off, data_off, s_idx, k_sel;
    logic        in_range, rd_hit, bus_clear;

    assign size  = wp - rp;
    assign full  = (size == DEPTH_CNT);
    assign empty = (size == '0);

    assign off       = addr_i - BASE16;
    assign data_off  = off - OFF_DATA;
    assign s_idx     = data_off >> SB;
    assign k_sel     = data_off & K_MASK;
    assign in_range  = ({1'b0, addr_i} >= ADDR_LO) && ({1'b0, addr_i} < ADDR_HI);
    assign rd_hit    = valid_i && !rw_i && in_range;
    assign bus_clear = valid_i && rw_i && in_range && (off == OFF_STATUS) && wdata_i[0];

    always_comb begin
        wp_nxt  = wp;
        rp_nxt  = rp;
        ovf_nxt = overflow;
        ram_we  = 1'b0;
        if (clear || bus_clear) begin
            // Pop is ignored on clear; a concurrent acquire lands in the emptied FIFO.
            rp_nxt  = wp;
            ovf_nxt = 1'b0;
            if (acquire) begin
                ram_we = 1'b1;
                wp_nxt = wp + PTR_ONE;
            end
        end else begin
            if (acquire) begin
                if (!full) begin
                    ram_we = 1'b1;
                    wp_nxt = wp + PTR_ONE;
                end else if (!mode) begin
                    ovf_nxt = 1'b1;
                end else begin
                    ram_we  = 1'b1;
                    wp_nxt  = wp + PTR_ONE;
                    rp_nxt  = rp + PTR_ONE;
                    ovf_nxt = 1'b1;
                end
            end
            // Stacks with an eviction, so pop + overwrite advances rp by two.
            if (pop && !empty) rp_nxt = rp_nxt + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp       <= '0;
            rp       <= '0;
            overflow <= 1'b0;
        end else begin
            wp       <= wp_nxt;
            rp       <= rp_nxt;
            overflow <= ovf_nxt;
        end
    end

    // ---------------- bus read side ----------------
    logic [AW-1:0]    ram_addra;
    logic [RAM_W-1:0] ram_douta;
    logic             use_ram;
    logic [15:0]      reg_val;

    assign ram_addra = rp[AW-1:0] + s_idx[AW-1:0];

    always_comb begin
        use_ram = 1'b0;
        reg_val = '0;
        if (off == OFF_STATUS) begin
            reg_val[ST_EMPTY]    = empty;
            reg_val[ST_FULL]     = full;
            reg_val[ST_OVERFLOW] = overflow;
            reg_val[ST_MODE]     = mode;
        end else if (off == OFF_SIZE) begin
            reg_val = 16'(size);
        end else if ((s_idx < 16'(size)) && (k_sel < 16'(WORDS))) begin
            use_ram = 1'b1;
        end
        // Out-of-bounds data reads leave reg_val at zero.
    end

    dual_port_bram #(
        .RAM_WIDTH (RAM_W),
        .RAM_DEPTH (SAMPLE_DEPTH)
    ) u_bram (
        .clka  (clk),
        .addra (ram_addra),
        .douta (ram_douta),
        .clkb  (clk),
        .addrb (wp[AW-1:0]),
        .dinb  (RAM_W'(probe_data)),
        .web   (ram_we)
    );

    logic [15:0] p1_addr, p1_wdata, p1_rdata, p1_reg_val, p1_k;
    logic        p1_rw, p1_valid, p1_hit, p1_use_ram;
    logic [15:0] ram_word;

    // The word select travels with the BRAM read and picks the word from douta.
    always_comb begin
        ram_word = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (p1_k == 16'(i)) ram_word = ram_douta[i*16 +: 16];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p1_addr    <= '0;
            p1_wdata   <= '0;
            p1_rdata   <= '0;
            p1_rw      <= 1'b0;
            p1_valid   <= 1'b0;
            p1_hit     <= 1'b0;
            p1_use_ram <= 1'b0;
            p1_reg_val <= '0;
            p1_k       <= '0;
            addr_o     <= '0;
            wdata_o    <= '0;
            rdata_o    <= '0;
            rw_o       <= 1'b0;
            valid_o    <= 1'b0;
        end else begin
            p1_addr    <= addr_i;
            p1_wdata   <= wdata_i;
            p1_rdata   <= rdata_i;
            p1_rw      <= rw_i;
            p1_valid   <= valid_i;
            p1_hit     <= rd_hit;
            p1_use_ram <= use_ram;
            p1_reg_val <= reg_val;
            p1_k       <= k_sel;
            addr_o     <= p1_addr;
            wdata_o    <= p1_wdata;
            rw_o       <= p1_rw;
            valid_o    <= p1_valid;
            rdata_o    <= p1_hit ? (p1_use_ram ? ram_word : p1_reg_val) : p1_rdata;
        end
    end

endmodule

// File: tb/tb_sample_mem_wide.sv
module tb_sample_mem_wide;

    localparam int BASE  = 256;
    localparam int DEPTH = 8;
    localparam int WIDTH = 40;
    localparam logic [15:0] B = 16'(BASE);

    logic              clk = 1'b0;
    logic              rst;
    logic [WIDTH-1:0]  probe_data;
    logic              acquire, mode, pop, clear;
    logic [3:0]        size;
    logic              full, overflow;
    logic [15:0]       addr_i, wdata_i, rdata_i, addr_o, wdata_o, rdata_o;
    logic              rw_i, valid_i, rw_o, valid_o;

    int checks = 0;
    int failures = 0;

    sample_mem_wide #(
        .BASE_ADDR    (BASE),
        .SAMPLE_DEPTH (DEPTH),
        .SAMPLE_WIDTH (WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .probe_data (probe_data),
        .acquire    (acquire),
        .mode       (mode),
        .pop        (pop),
        .clear      (clear),
        .size       (size),
        .full       (full),
        .overflow   (overflow),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .rdata_i    (rdata_i),
        .rw_i       (rw_i),
        .valid_i    (valid_i),
        .addr_o     (addr_o),
        .wdata_o    (wdata_o),
        .rdata_o    (rdata_o),
        .rw_o       (rw_o),
        .valid_o    (valid_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] rdata_in;
        logic [15:0] exp;
    } rd_vec_t;

    rd_vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // All tasks start and end right after a falling edge.
    task automatic acq(input logic [WIDTH-1:0] v);
        probe_data = v;
        acquire = 1'b1;
        @(negedge clk);
        acquire = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, input logic [15:0] rin,
                            output logic [15:0] d, output logic v, output logic [15:0] ao);
        addr_i = a; rw_i = 1'b0; valid_i = 1'b1; rdata_i = rin;
        @(negedge clk);
        valid_i = 1'b0;
        @(negedge clk);
        d = rdata_o; v = valid_o; ao = addr_o;
    endtask

    task automatic rd(input string name, input logic [15:0] a, input logic [15:0] exp);
        logic [15:0] d, ao;
        logic v;
        bus_read(a, 16'hDEAD, d, v, ao);
        check(name, d, exp);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        addr_i = a; wdata_i = d; rw_i = 1'b1; valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0; rw_i = 1'b0; wdata_i = '0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d, ao;
        logic v;

        rst = 1'b1; probe_data = '0; acquire = 0; mode = 0; pop = 0; clear = 0;
        addr_i = '0; wdata_i = '0; rdata_i = '0; rw_i = 0; valid_i = 0;

        vecs[0] = '{B + 16'd2,  16'hDEAD, 16'h5678};
        vecs[1] = '{B + 16'd3,  16'hDEAD, 16'h1234};
        vecs[2] = '{B + 16'd4,  16'hDEAD, 16'h00AB};
        vecs[3] = '{B + 16'd5,  16'hDEAD, 16'h0000};
        vecs[4] = '{B + 16'd6,  16'hDEAD, 16'h5679};
        vecs[5] = '{B + 16'd10, 16'hDEAD, 16'h567A};
        vecs[6] = '{B + 16'd14, 16'hDEAD, 16'h0000};
        vecs[7] = '{B + 16'd1,  16'hDEAD, 16'h0003};
        vecs[8] = '{B + 16'd0,  16'hDEAD, 16'h0000};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_size", size, 0);
        check("rst_full", full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_rdata", rdata_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_addr", addr_o, 0);

        // Wide samples, word order and bounds.
        for (int i = 0; i < 3; i++) acq(40'hAB_1234_5678 + 40'(i));
        check("t1_size", size, 3);
        for (int i = 0; i < 9; i++) begin
            logic [15:0] dd, aa;
            logic vv;
            bus_read(vecs[i].addr, vecs[i].rdata_in, dd, vv, aa);
            check($sformatf("t1_vec%0d", i), dd, vecs[i].exp);
        end

        // Stop-when-full.
        clear = 1'b1; @(negedge clk); clear = 1'b0;
        for (int i = 0; i < 10; i++) acq(40'h100 + 40'(i));
        check("t2_size", size, 8);
        check("t2_full", full, 1);
        check("t2_ovf", overflow, 1);
        rd("t2_s0", B + 16'd2, 16'h0100);
        rd("t2_s7", B + 16'd30, 16'h0107);
        rd("t2_status", B, 16'h0006);

        // Overwrite-oldest.
        clear = 1'b1; @(negedge clk); clear = 1'b0;
        check("t3_clr_size", size, 0);
        mode = 1'b1;
        for (int i = 0; i < 10; i++) acq(40'(i));
        check("t3_size", size, 8);
        rd("t3_s0", B + 16'd2, 16'h0002);
        rd("t3_s7", B + 16'd30, 16'h0009);
        rd("t3_status", B, 16'h000E);

        // Pop together with an evicting acquire.
        pop = 1'b1; probe_data = 40'd10; acquire = 1'b1;
        @(negedge clk);
        pop = 1'b0; acquire = 1'b0;
        check("t4_size", size, 7);
        check("t4_full", full, 0);
        rd("t4_s0", B + 16'd2, 16'h0004);
        rd("t4_s6", B + 16'd26, 16'h000A);
        rd("t4_s7_oob", B + 16'd30, 16'h0000);

        // Clear with concurrent acquire.
        clear = 1'b1; acquire = 1'b1; probe_data = 40'h55;
        @(negedge clk);
        clear = 1'b0; acquire = 1'b0;
        check("t5_size", size, 1);
        check("t5_ovf", overflow, 0);
        rd("t5_s0", B + 16'd2, 16'h0055);
        rd("t5_s0w1", B + 16'd3, 16'h0000);

        // Bus-side clear and ignored writes.
        mode = 1'b0;
        acq(40'h66);
        bus_write(B + 16'd1, 16'h0001);
        check("t6_size_wr", size, 2);
        bus_write(B, 16'h0002);
        check("t6_bit0_zero", size, 2);
        bus_write(B, 16'h0001);
        check("t6_bus_clear", size, 0);
        rd("t6_status", B, 16'h0001);
        rd("t6_empty_data", B + 16'd2, 16'h0000);

        // Pass-through outside the block, with exact latency.
        bus_read(B - 16'd1, 16'hBEEF, d, v, ao);
        check("t8_below_rdata", d, 16'hBEEF);
        check("t8_below_valid", v, 1);
        check("t8_below_addr", ao, B - 16'd1);
        bus_read(B + 16'd34, 16'hC0DE, d, v, ao);
        check("t8_above_rdata", d, 16'hC0DE);

        // Reset while a read is in flight.
        for (int i = 0; i < 9; i++) acq(40'h200 + 40'(i));
        check("t9_pre_ovf", overflow, 1);
        addr_i = B + 16'd2; rw_i = 1'b0; valid_i = 1'b1; rdata_i = 16'hBEEF;
        @(negedge clk);
        valid_i = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t9_size", size, 0);
        check("t9_full", full, 0);
        check("t9_ovf", overflow, 0);
        check("t9_rdata", rdata_o, 0);
        check("t9_valid", valid_o, 0);
        check("t9_addr", addr_o, 0);
        @(negedge clk);
        check("t9_no_resp", valid_o, 0);
        check("t9_no_rdata", rdata_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sample_mem_wide.md
# sample_mem_wide

Parametrised successor to the logic-analyzer sample memory. It captures probe samples of arbitrary width into a power-of-two-deep circular BRAM FIFO, with two capture modes: stop-when-full and overwrite-oldest for pre-trigger history. All samples, status and size are exposed oldest-first on the 16-bit register bus. It sits between the trigger/capture controller (acquire, pop, clear) and the bus daisy chain.

## Interface
- BASE_ADDR, 0: first bus address of the block.
- SAMPLE_DEPTH, 1024: samples stored; power of two, ≥2.
- SAMPLE_WIDTH, 16: probe bits per sample, 1..256.
- Derived localparams:
  - WORDS = ceil(SAMPLE_WIDTH/16).
  - STRIDE = next power of two ≥ WORDS.
  - AW = $clog2(SAMPLE_DEPTH).
  - Constraint: BASE_ADDR + 2 + SAMPLE_DEPTH·STRIDE ≤ 65536.
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- probe_data  in  SAMPLE_WIDTH  sample written on acquire.
- acquire  in  1  write one sample this cycle.
- mode  in  1  0 = stop when full; 1 = overwrite oldest.
- pop  in  1  discard the oldest sample.
- clear  in  1  empty the FIFO and clear overflow.
- size  out  AW+1  stored sample count, 0..SAMPLE_DEPTH.
- full  out  1  size == SAMPLE_DEPTH.
- overflow  out  1  sticky; set when a sample was dropped or evicted.
- addr_i/wdata_i/rdata_i  in  16 each; rw_i, valid_i  in  1 each: bus input.
- addr_o/wdata_o/rdata_o  out  16 each; rw_o, valid_o  out  1 each: bus output, registered.

## Operation
- Pointers wp and rp are AW+1 bits. size = wp − rp. Physical BRAM index = pointer[AW-1:0].
- Bus map, offsets from BASE_ADDR:
  - 0: status, read {12'b0, mode, overflow, full, empty}. A write with wdata bit0 = 1 acts as clear.
  - 1: size, zero-extended; read-only.
  - 2 + s·STRIDE + k: word k (LSBs first) of the s-th oldest sample.
  - Data reads return 0 when k ≥ WORDS or s ≥ size.
  - Reads use the rp value in the request cycle.
- Per-cycle update, in priority order:
  - rst: wp = rp = 0; overflow = 0.
  - clear (port or bus write): rp ← wp; overflow ← 0. pop is ignored that cycle. A concurrent acquire still writes, giving size = 1 afterwards.
  - acquire, not full: write at wp; wp+1.
  - acquire, full, mode 0: sample dropped; overflow ← 1.
  - acquire, full, mode 1: write at wp; wp+1; rp+1 (oldest evicted); overflow ← 1.
  - pop, size > 0: rp+1. Pop on empty is ignored.
  - pop together with a mode-1 full acquire: rp+2, so size = SAMPLE_DEPTH−1.
- Bus pass-through: all bus inputs are delayed 2 cycles to the outputs. rdata_o is replaced only for valid reads (!rw) inside the block's range. Writes to offsets other than 0 are ignored.

## Timing
- Capture: sample visible to a bus read issued the cycle after acquire. size/full update 1 cycle after acquire/pop/clear.
- Bus latency is exactly 2 cycles; back-to-back requests every cycle are supported.
- Reset values: size 0, full 0, overflow 0, all bus outputs 0.
- rst mid-read: in-flight pipeline stages are zeroed; no response is produced.
- Pointer wrap past 2^(AW+1) is seamless; size arithmetic is modular.

## Structure
- Shared package sample_mem_pkg holds:
  - status bit positions;
  - register offsets (STATUS = 0, SIZE = 1, DATA = 2);
  - the STRIDE/WORDS helper functions.
- One sub-module: existing dual_port_bram, RAM_WIDTH = WORDS·16 (probe zero-padded), RAM_DEPTH = SAMPLE_DEPTH.
  - Port a: bus read.
  - Port b: capture write.
- The word select k is pipelined alongside the BRAM latency and muxes douta in the second stage.

## Test plan
- WIDTH = 40, DEPTH = 8, mode 0: acquire 3 samples 0xAB_1234_5678 + i, then read BASE+2..BASE+5.
  - Expect 0x5678, 0x1234, 0x00AB, 0x0000 for i = 0.
  - Expect size = 3.
- Mode 0: acquire 10.
  - Expect size 8, full 1, overflow 1.
  - Expect sample 0 = first value written.
- Mode 1: acquire 10 values 0..9.
  - Expect sample 0 = 2, sample 7 = 9, size 8, status = 0x000E.
- Full in mode 1, then pop and acquire in the same cycle.
  - Expect size 7 and oldest sample advanced by 2.
- Clear together with acquire of 0x55.
  - Expect size 1, overflow 0, sample 0 = 0x55.
- Bus write of 1 to BASE+0: acts as clear.
- Read of s ≥ size: returns 0.
- Out-of-range read of BASE−1: passes rdata_i unchanged after 2 cycles.
- rst mid-stream: all outputs 0 on the next cycle.
